input_controller: RTL and testbench
===================================

// Module: input_controller
// PURPOSE
//  Receive side of the host UART link, the counterpart of the core's output path.
//  Deserialises 8N1 frames on rxd with an internal oversampling receiver FSM.
//  mode=0: bytes are queued in a circular buffer that the core drains via read_input/input_data.
//  mode=1: each byte is presented directly as a one-cycle recv_valid pulse, for loader handshakes.
// PARAMETERS
//  CLKS_PER_BIT  868   clk cycles per UART bit (100 MHz / 115200); must be >= 8
//  BUFFER_SIZE   2048  buffer depth in bytes; must be a power of two
// PORTS
//  clk         in   1    system clock; single clock domain
//  rst         in   1    synchronous reset, active-high
//  rxd         in   1    UART serial input; asynchronous, idles high
//  mode        in   1    0 = buffered (DMA), 1 = single-byte signal
//  read_input  in   1    core requests one byte from the buffer this cycle
//  input_data  out  8    byte at the buffer head; combinational from the head entry
//  stall       out  1    empty & read_input; the core must hold the read
//  recv_valid  out  1    mode=1 only: one-cycle pulse when a byte is received
//  recv_byte   out  8    last byte received in mode=1; held until the next pulse
//  count       out  clog2(BUFFER_SIZE)+1  bytes currently buffered
//  overrun     out  1    sticky: a byte was dropped because the buffer was full
//  frame_err   out  1    one-cycle pulse: bad stop bit, frame discarded
// BEHAVIOUR
//  Reset values: all outputs 0 except input_data (don't care). raddr=waddr=count=0, FSM=IDLE,
//   synchroniser flops=1. Reset mid-frame or with data buffered: everything is discarded immediately.
//  rxd path: 2-flop synchroniser, called rxs below. Every sample point uses rxs.
//  RX FSM, with a bit-cycle counter cnt:
//   IDLE  : rxs==0 -> START, cnt=0
//   START : at cnt==CLKS_PER_BIT/2-1, rxs==0 -> DATA with cnt=0, bit=0; rxs==1 -> IDLE (glitch)
//   DATA  : at cnt==CLKS_PER_BIT-1, shift rxs into bit[bit] (LSB first) and reset cnt;
//           after bit 7 -> STOP
//   STOP  : at cnt==CLKS_PER_BIT-1, rxs==1 -> deliver the byte; rxs==0 -> frame_err pulse, no delivery.
//           Both cases -> IDLE. A held break line therefore yields repeated frame errors.
//  Delivery happens on the clock edge that samples the stop bit (edge E):
//   mode=1: recv_byte<=byte and recv_valid<=1 for 1 cycle; the buffer is untouched.
//   mode=0: push to mem[waddr]; waddr wraps BUFFER_SIZE-1 -> 0.
//  Push and pop rules:
//   push is accepted if count<BUFFER_SIZE, or if a pop occurs in the same cycle.
//   A push that is not accepted drops the byte and sets overrun; overrun is cleared only by rst.
//   pop = read_input & (count!=0). raddr increments with the same wrap rule.
//   The core samples input_data in the same cycle as the pop.
//   Push and pop together: both take effect and count is unchanged (including when full).
//   count==0 with push and read_input together: stall=1 and the push is stored;
//    input_data is valid on the next cycle.
//  Latency: stop-bit sample edge E -> count/input_data updated at E -> stall deasserts cycle E+1.
//  Changing mode mid-frame: the mode value sampled at delivery selects the path.
//   Buffered bytes stay in the buffer and can still be read in either mode.
// TESTING (CLKS_PER_BIT=16, BUFFER_SIZE=4)
//  Send frame 0xA5, mode=0, no read -> count=1, input_data=0xA5, stall=0; read_input 1 cycle -> count=0.
//  read_input held high while buffer empty, then frame 0x3C -> stall=1 until the cycle after the
//   stop sample, then 0x3C is consumed and count returns to 0.
//  Send 5 frames 0x01..0x05 with no reads -> count=4, overrun=1;
//   then read 4 -> 0x01,0x02,0x03,0x04 (wrap exercised).
//  Stop bit driven 0 on frame 0x55 -> frame_err pulse, count unchanged;
//   a 4-cycle low glitch -> no frame, FSM back in IDLE.
//  mode=1, frame 0x7E -> recv_valid high exactly 1 cycle, recv_byte=0x7E, count stays 0.
//  Buffer full plus frame 0x99 with read_input asserted on the stop-sample cycle ->
//   no overrun, count stays 4, 0x99 is the last byte read.

Source files
------------

// File: rtl/input_controller.sv
// ============================================================================
// Module   : input_controller
// Brief    : Host UART receiver (8N1) feeding a circular byte buffer or a
//            direct single-byte strobe interface.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module input_controller #(
    parameter int CLKS_PER_BIT = 868,
    parameter int BUFFER_SIZE  = 2048
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rxd,
    input  logic                           mode,
    input  logic                           read_input,
    output logic [7:0]                     input_data,
    output logic                           stall,
    output logic                           recv_valid,
    output logic [7:0]                     recv_byte,
    output logic [$clog2(BUFFER_SIZE):0]   count,
    output logic                           overrun,
    output logic                           frame_err
);

    localparam int                c_cw        = $clog2(CLKS_PER_BIT);
    localparam int                c_aw        = $clog2(BUFFER_SIZE);
    localparam logic [c_cw-1:0]   c_half_last = c_cw'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cw-1:0]   c_bit_last  = c_cw'(CLKS_PER_BIT - 1);
    localparam logic [c_aw:0]     c_depth     = (c_aw + 1)'(BUFFER_SIZE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic            r_sync1, r_sync2;
    state_t          r_state, w_state_nxt;
    logic [c_cw-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]      r_bit, w_bit_nxt;
    logic [7:0]      r_shreg, w_shreg_nxt;
    logic            w_deliver, w_ferr;

    logic [7:0]      r_mem [BUFFER_SIZE];
    logic [c_aw-1:0] r_waddr, r_raddr;
    logic [c_aw:0]   r_count, w_count_nxt;
    logic            r_overrun, r_recv_valid, r_frame_err;
    logic [7:0]      r_recv_byte;
    logic            w_push, w_pop, w_push_ok;

    // rxd is asynchronous; every sample point uses the second flop (rxs)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shreg <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shreg <= w_shreg_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_bit_nxt   = r_bit;
        w_shreg_nxt = r_shreg;
        w_deliver   = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!r_sync2) w_state_nxt = S_START;
            end
            S_START: begin
                if (r_cnt == c_half_last) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = r_sync2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == c_bit_last) begin
                    w_cnt_nxt   = '0;
                    w_shreg_nxt = {r_sync2, r_shreg[7:1]};
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (r_cnt == c_bit_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    w_deliver   = r_sync2;
                    w_ferr      = ~r_sync2;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A pop frees a slot in the same cycle, so a full buffer still accepts
    assign w_push    = w_deliver & ~mode;
    assign w_pop     = read_input & (r_count != '0);
    assign w_push_ok = w_push & ((r_count != c_depth) | w_pop);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_ok, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_waddr] <= r_shreg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_waddr      <= '0;
            r_raddr      <= '0;
            r_count      <= '0;
            r_overrun    <= 1'b0;
            r_recv_valid <= 1'b0;
            r_recv_byte  <= '0;
            r_frame_err  <= 1'b0;
        end else begin
            r_count      <= w_count_nxt;
            r_recv_valid <= w_deliver & mode;
            r_frame_err  <= w_ferr;
            if (w_push_ok)           r_waddr     <= r_waddr + 1'b1;
            if (w_pop)               r_raddr     <= r_raddr + 1'b1;
            if (w_push & ~w_push_ok) r_overrun   <= 1'b1;
            if (w_deliver & mode)    r_recv_byte <= r_shreg;
        end
    end

    assign input_data = r_mem[r_raddr];
    assign stall      = read_input & (r_count == '0);
    assign recv_valid = r_recv_valid;
    assign recv_byte  = r_recv_byte;
    assign count      = r_count;
    assign overrun    = r_overrun;
    assign frame_err  = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_input_controller.sv
// ============================================================================
// Module   : tb_input_controller
// Brief    : Directed self-checking bench for input_controller (16 clk/bit,
//            4-byte buffer).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_input_controller;

    localparam int c_cpb = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       mode = 1'b0;
    logic       read_input = 1'b0;
    logic [7:0] input_data;
    logic       stall;
    logic       recv_valid;
    logic [7:0] recv_byte;
    logic [2:0] count;
    logic       overrun;
    logic       frame_err;

    int n_checks = 0;
    int n_errors = 0;
    int recv_pulses = 0;
    int ferr_pulses = 0;

    input_controller #(
        .CLKS_PER_BIT (c_cpb),
        .BUFFER_SIZE  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .mode       (mode),
        .read_input (read_input),
        .input_data (input_data),
        .stall      (stall),
        .recv_valid (recv_valid),
        .recv_byte  (recv_byte),
        .count      (count),
        .overrun    (overrun),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (recv_valid) recv_pulses++;
        if (frame_err)  ferr_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the stop bit
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [7:0] v;
        v = b;
        rxd = 1'b0;
        repeat (c_cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = v[i];
            repeat (c_cpb) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (c_cpb) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2);
    endtask

    logic [7:0] exp_bytes [4];
    logic       seen, stall_dropped;

    initial begin
        do_reset();
        check("rst_count", count, 0);
        check("rst_overrun", overrun, 0);
        check("rst_recv_valid", recv_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_stall", stall, 0);

        // single buffered byte
        send_frame(8'hA5, 1'b1);
        idle(4);
        check("a5_count", count, 1);
        check("a5_data", input_data, 8'hA5);
        check("a5_stall", stall, 0);
        read_input = 1'b1;
        @(negedge clk);
        read_input = 1'b0;
        check("a5_count_after_read", count, 0);

        // read held against an empty buffer
        read_input = 1'b1;
        #1;
        check("empty_stall", stall, 1);
        @(negedge clk);
        seen = 1'b0;
        stall_dropped = 1'b0;
        fork
            send_frame(8'h3C, 1'b1);
            begin
                for (int i = 0; i < 300 && !seen; i++) begin
                    @(negedge clk);
                    if (count != 0) begin
                        seen = 1'b1;
                        check("3c_stall_released", stall, 0);
                        check("3c_data", input_data, 8'h3C);
                    end else if (!stall) begin
                        stall_dropped = 1'b1;
                    end
                end
            end
        join
        read_input = 1'b0;
        check("3c_arrived", seen, 1);
        check("3c_stall_held", stall_dropped, 0);
        check("3c_consumed", count, 0);

        // overflow and wrap
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1);
            idle(4);
        end
        check("ovf_count", count, 4);
        check("ovf_flag", overrun, 1);
        read_input = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("ovf_read", input_data, 32'(i));
            @(negedge clk);
        end
        read_input = 1'b0;
        check("ovf_drained", count, 0);
        check("mode0_no_recv_valid", recv_pulses, 0);

        // bad stop bit, then a short glitch, then a good frame
        send_frame(8'h55, 1'b0);
        idle(20);
        check("ferr_pulse", ferr_pulses, 1);
        check("ferr_count", count, 0);
        rxd = 1'b0;
        idle(4);
        rxd = 1'b1;
        idle(40);
        check("glitch_count", count, 0);
        check("glitch_no_ferr", ferr_pulses, 1);
        send_frame(8'h5A, 1'b1);
        idle(4);
        check("post_glitch_count", count, 1);
        check("post_glitch_data", input_data, 8'h5A);
        read_input = 1'b1;
        @(negedge clk);
        read_input = 1'b0;

        // direct single-byte mode
        mode = 1'b1;
        send_frame(8'h7E, 1'b1);
        idle(4);
        check("m1_pulse_cycles", recv_pulses, 1);
        check("m1_byte", recv_byte, 8'h7E);
        check("m1_count", count, 0);
        mode = 1'b0;

        // full buffer with a pop on the stop-sample cycle
        do_reset();
        exp_bytes[0] = 8'h22;
        exp_bytes[1] = 8'h33;
        exp_bytes[2] = 8'h44;
        exp_bytes[3] = 8'h99;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        idle(4);
        check("full_count", count, 4);
        fork
            send_frame(8'h99, 1'b1);
            begin
                repeat (154) @(negedge clk);
                read_input = 1'b1;
                @(negedge clk);
                read_input = 1'b0;
            end
        join
        idle(4);
        check("full_pp_count", count, 4);
        check("full_pp_overrun", overrun, 0);
        read_input = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("full_pp_read", input_data, exp_bytes[i]);
            @(negedge clk);
        end
        read_input = 1'b0;
        check("full_pp_drained", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
